ntt_stage_ctrl: RTL
===================

NTT_STAGE_CTRL -- requirements
Module: ntt_stage_ctrl

Interface
REQ-001 SHALL have parameter LOG_N, default 4, meaning log2 of transform length N (N=16).
REQ-002 SHALL have parameter BU_LATENCY, default 4, meaning butterfly input-to-output latency in cycles.
REQ-003 SHALL have parameter RD_LATENCY, default 1, meaning coefficient-memory read latency in cycles.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, meaning a one-cycle request to run a full N-point transform.
REQ-007 SHALL have port busy, output, 1, meaning a transform is in progress.
REQ-008 SHALL have port done, output, 1, meaning a one-cycle pulse at transform completion.
REQ-009 SHALL have port rd_en, output, 1, meaning read strobe for the butterfly operand pair.
REQ-010 SHALL have ports rd_addr_a and rd_addr_b, output, LOG_N each, meaning operand addresses.
REQ-011 SHALL have port tw_idx, output, LOG_N-1, meaning the twiddle exponent of omega_N for the current butterfly.
REQ-012 SHALL have port bu_in_valid, output, 1, meaning read data presented to the butterfly this cycle.
REQ-013 SHALL have port wr_en, output, 1, meaning butterfly results are written back this cycle.
REQ-014 SHALL have ports wr_addr_a and wr_addr_b, output, LOG_N each, meaning write-back addresses for fft_a and fft_b.
REQ-015 SHALL have port stage, output, clog2(LOG_N), meaning the index of the stage currently issuing.

Function
REQ-016 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> (ISSUE | FIN) -> IDLE.
REQ-017 SHALL, in IDLE, sample start=1 and move to ISSUE with stage=0 and k=0; start SHALL be ignored outside IDLE.
REQ-018 SHALL, in ISSUE, assert registered rd_en for exactly N/2 consecutive cycles per stage, one butterfly k=0..N/2-1 per cycle.
REQ-019 SHALL address in decimation-in-frequency order: m=N>>(s+1), g=k/m, j=k%m, rd_addr_a=g*2m+j, rd_addr_b=rd_addr_a+m, tw_idx=j<<s.
REQ-020 SHALL assert bu_in_valid exactly RD_LATENCY cycles after each rd_en, and wr_en with the matching addresses exactly RD_LATENCY+BU_LATENCY cycles after each rd_en, via an address/valid shift register.
REQ-021 SHALL enter DRAIN after the last issue of a stage and hold there until that stage's last wr_en has occurred.
REQ-022 SHALL issue the next stage's first rd_en no earlier than the cycle after the previous stage's last wr_en (read-after-write barrier).
REQ-023 SHALL, after the final stage drains, go to FIN, pulse done for one cycle, and return to IDLE.
REQ-024 SHALL hold busy=1 from the cycle after start is sampled through the final wr_en cycle inclusive, and busy=0 while done=1.
REQ-025 SHALL hold rd_addr_*, tw_idx and wr_addr_* at 0 whenever the corresponding strobe is 0.
REQ-026 SHALL, with default parameters, give a stage period of N/2+RD_LATENCY+BU_LATENCY = 13 cycles, and for start sampled at edge 0 give rd_en on cycles 1-8, wr_en on cycles 6-13, stage-1 rd_en from cycle 14, and done on cycle 53.
REQ-027 SHALL use no comparators wider than LOG_N bits, and SHALL wrap k and stage counters without overflow at their terminal values.

Reset
REQ-028 SHALL, while rst_n=0, immediately force FSM=IDLE and all outputs, counters and shift-register stages to 0.
REQ-029 SHALL, on reset assertion mid-transform, discard all in-flight writes; no wr_en SHALL follow reset release until a new start.
REQ-030 SHALL treat a start coincident with the first rising edge after rst_n deassertion as a valid start.

Verification
REQ-031 Bench SHALL check the single run: start at cycle 0 -> rd_en cycles 1-8 with (a,b,tw) = (0,8,0),(1,9,1)...(7,15,7); done at 53.
REQ-032 Bench SHALL check stage-3 addressing: pairs (0,1),(2,3)...(14,15), all with tw_idx=0; stage-1 pair k=5 -> (9,13, tw=2).
REQ-033 Bench SHALL check start ignored: start pulsed at cycles 5 and 30 -> a single done at 53, unchanged schedule.
REQ-034 Bench SHALL check reset mid-run: rst_n=0 at cycle 20 for 2 cycles -> all outputs 0 and no wr_en; a restart runs a clean 53-cycle schedule.
REQ-035 Bench SHALL check end to end: controller + BU2_FFT + memory model on the 16-point vector 0..15 -> results match the software DIF NTT (bit-reversed order).
REQ-036 Bench SHALL check back-to-back runs: start on the cycle after done -> a second identical schedule with no overlap between wr_en and rd_en across the runs.

Source files
------------

// File: rtl/ntt_stage_ctrl.sv
// ntt_stage_ctrl: decimation-in-frequency NTT stage sequencer.
// Issues one butterfly read per cycle and retires writes via a delay line.
module ntt_stage_ctrl #(
   parameter int  LOG_N      = 4,
   parameter int  BU_LATENCY = 4,
   parameter int  RD_LATENCY = 1,
   localparam int SW         = (LOG_N > 1) ? $clog2(LOG_N) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             rd_en,
   output logic [LOG_N-1:0] rd_addr_a,
   output logic [LOG_N-1:0] rd_addr_b,
   output logic [LOG_N-2:0] tw_idx,
   output logic             bu_in_valid,
   output logic             wr_en,
   output logic [LOG_N-1:0] wr_addr_a,
   output logic [LOG_N-1:0] wr_addr_b,
   output logic [SW-1:0]    stage
);

   localparam int N    = 1 << LOG_N;
   localparam int HALF = N / 2;
   localparam int KW   = LOG_N - 1;
   localparam int PL   = RD_LATENCY + BU_LATENCY;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_FIN
   } state_t;

   state_t r_state;
   state_t w_nxt;

   logic [KW-1:0]    r_k;
   logic [SW-1:0]    r_stage;
   logic [KW-1:0]    r_tw;
   logic             r_busy;
   logic             r_done;

   // Delay line: index 0 is the issue register, index PL is write-back.
   logic [PL:0]      r_vld;
   logic [PL-1:0]    r_last;
   logic [LOG_N-1:0] r_pa [0:PL];
   logic [LOG_N-1:0] r_pb [0:PL];

   logic             w_issue;
   logic             w_go;
   logic             w_adv;
   logic             w_k_last;
   logic             w_s_last;
   logic             w_drained;
   logic [LOG_N-1:0] w_m;
   logic [LOG_N-1:0] w_jmask;
   logic [LOG_N-1:0] w_kx;
   logic [LOG_N-1:0] w_lo;
   logic [LOG_N-1:0] w_hi;
   logic [LOG_N-1:0] w_a;
   logic [LOG_N-1:0] w_b;
   logic [KW-1:0]    w_tw;

   assign w_k_last  = (r_k == {KW{1'b1}});
   assign w_s_last  = (r_stage == SW'(LOG_N - 1));
   assign w_drained = r_vld[PL-1] & r_last[PL-1];

   // Butterfly addressing: insert a zero bit at log2(m) to split k into g,j.
   always_comb begin
      w_m     = LOG_N'(HALF) >> r_stage;
      w_jmask = w_m - LOG_N'(1);
      w_kx    = {1'b0, r_k};
      w_lo    = w_kx & w_jmask;
      w_hi    = (w_kx & ~w_jmask) << 1;
      w_a     = w_hi | w_lo;
      w_b     = w_a | w_m;
      w_tw    = KW'(w_lo << r_stage);
   end

   // Next-state and per-cycle control strobes.
   always_comb begin
      w_nxt   = r_state;
      w_issue = 1'b0;
      w_go    = 1'b0;
      w_adv   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_go  = 1'b1;
               w_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_issue = 1'b1;
            if (w_k_last) begin
               w_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_drained) begin
               w_adv = 1'b1;
               w_nxt = w_s_last ? S_FIN : S_ISSUE;
            end
         end
         S_FIN: begin
            w_nxt = S_IDLE;
         end
         default: begin
            w_nxt = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nxt;
      end
   end

   // Butterfly index and stage counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k     <= '0;
         r_stage <= '0;
      end else if (w_go) begin
         r_k     <= '0;
         r_stage <= '0;
      end else if (w_issue) begin
         r_k <= r_k + KW'(1);
      end else if (w_adv) begin
         r_stage <= w_s_last ? '0 : r_stage + SW'(1);
      end
   end

   // Issue register followed by the address/valid delay line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld  <= '0;
         r_last <= '0;
         r_tw   <= '0;
         for (int i = 0; i <= PL; i++) begin
            r_pa[i] <= '0;
            r_pb[i] <= '0;
         end
      end else begin
         r_vld[0]  <= w_issue;
         r_last[0] <= w_issue & w_k_last;
         r_pa[0]   <= w_issue ? w_a : '0;
         r_pb[0]   <= w_issue ? w_b : '0;
         r_tw      <= w_issue ? w_tw : '0;
         for (int i = 1; i <= PL; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_pa[i]  <= r_pa[i-1];
            r_pb[i]  <= r_pb[i-1];
         end
         for (int i = 1; i < PL; i++) begin
            r_last[i] <= r_last[i-1];
         end
      end
   end

   // Busy spans issue and drain; done follows the final drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= (r_state == S_ISSUE) || (r_state == S_DRAIN);
         r_done <= (r_state == S_FIN);
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign rd_en       = r_vld[0];
   assign rd_addr_a   = r_pa[0];
   assign rd_addr_b   = r_pb[0];
   assign tw_idx      = r_tw;
   assign bu_in_valid = r_vld[RD_LATENCY];
   assign wr_en       = r_vld[PL];
   assign wr_addr_a   = r_pa[PL];
   assign wr_addr_b   = r_pb[PL];
   assign stage       = r_stage;

endmodule
